// File: rtl/fft_frame_loader.sv
// Ping-pong frame assembler feeding the 32-point FFT butterfly input register.
// Define FFT_LOADER_BITREV_EN to store samples in bit-reversed (DIT) slot order.
module fft_frame_loader #(
    parameter int N_PTS       = 32,
    parameter int SAMPLE_W    = 64,
    parameter int HOLD_CYCLES = 8
) (
    input  logic                      clk2,
    input  logic                      reset,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [SAMPLE_W-1:0]       s_data,
    input  logic                      s_last,
    output logic [N_PTS*SAMPLE_W-1:0] frame_data,
    output logic                      frame_valid,
    output logic                      frame_start,
    output logic                      frame_err,
    output logic [15:0]               frame_cnt,
    output logic [0:0]                wr_state
);

    // Stream handshake: a sample transfers on every clk2 edge where s_valid && s_ready;
    // s_ready depends only on the write FSM state, never on s_valid.

    localparam logic [0:0] ST_FILL = 1'b0;
    localparam logic [0:0] ST_FULL = 1'b1;
    localparam logic [4:0] LAST_IDX = 5'd31;
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

    logic [N_PTS*SAMPLE_W-1:0] bank [2];
    logic [0:0]                state_q;
    logic [4:0]                wr_cnt;
    logic [4:0]                slot;
    logic                      rd_ptr;
    logic                      wr_sel;
    logic [7:0]                hold_cnt;
    logic                      accept;
    logic                      swap;
    logic                      hold_done;

    assign wr_sel    = ~rd_ptr;
    assign s_ready   = (state_q == ST_FILL);
    assign accept    = s_valid && s_ready;
    assign hold_done = (hold_cnt == HOLD_LAST);
    assign swap      = (state_q == ST_FULL) && (!frame_valid || hold_done);
    assign wr_state  = state_q;

    // The read bank is selected directly, so frame_data can only move when rd_ptr toggles.
    assign frame_data = bank[rd_ptr];

`ifdef FFT_LOADER_BITREV_EN
    assign slot = {wr_cnt[0], wr_cnt[1], wr_cnt[2], wr_cnt[3], wr_cnt[4]};
`else
    assign slot = wr_cnt;
`endif

    always_ff @(posedge clk2) begin
        if (reset) begin
            bank[0]     <= '0;
            bank[1]     <= '0;
            state_q     <= ST_FILL;
            wr_cnt      <= '0;
            rd_ptr      <= 1'b0;
            hold_cnt    <= '0;
            frame_valid <= 1'b0;
            frame_start <= 1'b0;
            frame_err   <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            if (accept) begin
                bank[wr_sel][int'(slot)*SAMPLE_W +: SAMPLE_W] <= s_data;
                if (wr_cnt == LAST_IDX) begin
                    state_q <= ST_FULL;
                    wr_cnt  <= '0;
                end else if (s_last) begin
                    // Early end-of-frame: drop the partial frame and restart the bank.
                    frame_err <= 1'b1;
                    wr_cnt    <= '0;
                end else begin
                    wr_cnt <= wr_cnt + 5'd1;
                end
            end

            if (swap) begin
                rd_ptr      <= ~rd_ptr;
                frame_valid <= 1'b1;
                frame_start <= 1'b1;
                hold_cnt    <= '0;
                frame_cnt   <= frame_cnt + 16'd1;
                state_q     <= ST_FILL;
            end else begin
                frame_start <= 1'b0;
                if (frame_valid) begin
                    if (hold_done) begin
                        frame_valid <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_fft_frame_loader.sv
// Directed bench for fft_frame_loader: default hold (8) instance plus a HOLD_CYCLES=40 instance.
module tb_fft_frame_loader;

    logic clk2 = 1'b0;
    always #5 clk2 = ~clk2;

    logic          reset;
    logic          a_valid, a_ready, a_last, a_fv, a_fs, a_err;
    logic [63:0]   a_data;
    logic [2047:0] a_frame;
    logic [15:0]   a_cnt;
    logic [0:0]    a_state;
    logic          b_valid, b_ready, b_last, b_fv, b_fs, b_err;
    logic [63:0]   b_data;
    logic [2047:0] b_frame;
    logic [15:0]   b_cnt;
    logic [0:0]    b_state;

    int n_checks = 0;
    int n_fail   = 0;

    fft_frame_loader dut_a (
        .clk2(clk2), .reset(reset), .s_valid(a_valid), .s_ready(a_ready),
        .s_data(a_data), .s_last(a_last), .frame_data(a_frame), .frame_valid(a_fv),
        .frame_start(a_fs), .frame_err(a_err), .frame_cnt(a_cnt), .wr_state(a_state)
    );

    fft_frame_loader #(.HOLD_CYCLES(40)) dut_b (
        .clk2(clk2), .reset(reset), .s_valid(b_valid), .s_ready(b_ready),
        .s_data(b_data), .s_last(b_last), .frame_data(b_frame), .frame_valid(b_fv),
        .frame_start(b_fs), .frame_err(b_err), .frame_cnt(b_cnt), .wr_state(b_state)
    );

    function automatic logic [63:0] samp(input int k);
        logic [31:0] re;
        logic [31:0] im;
        re = 32'(k);
        im = 32'(-k);
        return {re, im};
    endfunction

    // Write index whose sample lands in slot s.
    function automatic int rmap(input int s);
        logic [4:0] v;
        v = 5'(s);
`ifdef FFT_LOADER_BITREV_EN
        return int'({v[0], v[1], v[2], v[3], v[4]});
`else
        return int'(v);
`endif
    endfunction

    function automatic logic [63:0] slot_of(input logic [2047:0] f, input int s);
        return f[s*64 +: 64];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Sends n samples samp(base+i); s_last on index last_idx. Returns #1 after the last accept.
    task automatic send_a(input int base, input int n, input int last_idx);
        for (int i = 0; i < n; i++) begin
            int w;
            a_valid = 1'b1;
            a_data  = samp(base + i);
            a_last  = (i == last_idx);
            w = 0;
            while (!a_ready && w < 100) begin
                @(posedge clk2); #1;
                w++;
            end
            if (w >= 100) check("send_a_timeout", 64'(w), 64'd0);
            @(posedge clk2); #1;
        end
        a_valid = 1'b0;
        a_last  = 1'b0;
    endtask

    initial begin
        int hv, pulses, idx, stalls, guard, n, gap, rdy_hi;
        logic rdy;
        reset = 1'b1;
        a_valid = 1'b0; a_last = 1'b0; a_data = '0;
        b_valid = 1'b0; b_last = 1'b0; b_data = '0;

        // T1 reset
        repeat (3) @(posedge clk2);
        #1;
        check("t1_fv", 64'(a_fv), 64'd0);
        check("t1_fs", 64'(a_fs), 64'd0);
        check("t1_err", 64'(a_err), 64'd0);
        check("t1_cnt", 64'(a_cnt), 64'd0);
        check("t1_frame_or", 64'(|a_frame), 64'd0);
        reset = 1'b0;
        @(posedge clk2); #1;
        check("t1_ready", 64'(a_ready), 64'd1);
        check("t1_b_ready", 64'(b_ready), 64'd1);

        // T2 one frame, continuous valid
        send_a(0, 32, -1);
        check("t2_fv_before", 64'(a_fv), 64'd0);
        check("t2_ready_full", 64'(a_ready), 64'd0);
        @(posedge clk2); #1;
        check("t2_fs", 64'(a_fs), 64'd1);
        check("t2_fv", 64'(a_fv), 64'd1);
        check("t2_ready_back", 64'(a_ready), 64'd1);
        check("t2_cnt", 64'(a_cnt), 64'd1);
        check("t2_slot0", slot_of(a_frame, 0), samp(rmap(0)));
        check("t2_slot5", slot_of(a_frame, 5), samp(rmap(5)));
        check("t2_slot16", slot_of(a_frame, 16), samp(rmap(16)));
        check("t2_slot24", slot_of(a_frame, 24), samp(rmap(24)));
        check("t2_slot31", slot_of(a_frame, 31), samp(31));
        hv = 0; pulses = 0;
        while (a_fv && hv < 50) begin
            hv++;
            if (a_fs) pulses++;
            @(posedge clk2); #1;
        end
        check("t2_valid_len", 64'(hv), 64'd8);
        check("t2_start_pulses", 64'(pulses), 64'd1);
        check("t2_frame_kept", slot_of(a_frame, 5), samp(rmap(5)));
        check("t2_err", 64'(a_err), 64'd0);

        // T5 early s_last
        send_a(50, 11, 10);
        check("t5_err", 64'(a_err), 64'd1);
        check("t5_ready", 64'(a_ready), 64'd1);
        @(posedge clk2); #1;
        check("t5_no_start", 64'(a_fs), 64'd0);
        check("t5_cnt_hold", 64'(a_cnt), 64'd1);
        send_a(100, 32, 31);
        @(posedge clk2); #1;
        check("t5_fs", 64'(a_fs), 64'd1);
        check("t5_cnt", 64'(a_cnt), 64'd2);
        check("t5_err_sticky", 64'(a_err), 64'd1);
        check("t5_slot0", slot_of(a_frame, 0), samp(100 + rmap(0)));
        check("t5_slot3", slot_of(a_frame, 3), samp(100 + rmap(3)));
        check("t5_slot31", slot_of(a_frame, 31), samp(131));

        // T6 reset discards partial frame
        repeat (10) @(posedge clk2);
        #1;
        send_a(1000, 20, -1);
        reset = 1'b1;
        @(posedge clk2); #1;
        reset = 1'b0;
        check("t6_err_clr", 64'(a_err), 64'd0);
        check("t6_cnt_clr", 64'(a_cnt), 64'd0);
        send_a(200, 32, -1);
        @(posedge clk2); #1;
        check("t6_fs", 64'(a_fs), 64'd1);
        check("t6_cnt", 64'(a_cnt), 64'd1);
        for (int s = 0; s < 32; s++) begin
            check($sformatf("t6_slot%0d", s), slot_of(a_frame, s), samp(200 + rmap(s)));
        end

        // T4 HOLD_CYCLES=40, 64 samples continuously on instance b
        idx = 0; stalls = 0; guard = 0;
        while (idx < 64 && guard < 500) begin
            b_valid = 1'b1;
            b_data  = samp(idx);
            rdy = b_ready;
            if (!rdy) stalls++;
            @(posedge clk2); #1;
            if (rdy) idx++;
            guard++;
        end
        b_valid = 1'b0;
        check("t4_all_sent", 64'(idx), 64'd64);
        check("t4_stream_stalls", 64'(stalls), 64'd1);
        check("t4_cnt_mid", 64'(b_cnt), 64'd1);
        n = 0; gap = 0; rdy_hi = 0;
        while (!b_fs && n < 100) begin
            if (!b_fv) gap++;
            if (b_ready) rdy_hi++;
            @(posedge clk2); #1;
            n++;
        end
        check("t4_wait_cycles", 64'(n), 64'd8);
        check("t4_valid_gap", 64'(gap), 64'd0);
        check("t4_ready_low", 64'(rdy_hi), 64'd0);
        check("t4_fv", 64'(b_fv), 64'd1);
        check("t4_ready_back", 64'(b_ready), 64'd1);
        check("t4_cnt", 64'(b_cnt), 64'd2);
        check("t4_slot0", slot_of(b_frame, 0), samp(32 + rmap(0)));
        check("t4_slot5", slot_of(b_frame, 5), samp(32 + rmap(5)));
        check("t4_slot31", slot_of(b_frame, 31), samp(63));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
